// File: rtl/spi_burst_fifo.sv
// MMIO front-end that queues bytes into a TX FIFO, runs one SPI byte transfer per entry and
// collects the replies in an RX FIFO. Optional chip-select output enabled by SPI_BURST_CS_EN.
module spi_burst_fifo #(
    parameter int DEPTH_LOG2   = 3,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  mem_addr,
    input  logic [3:0]  mem_wr_en,
    input  logic [31:0] mem_wr_data,
    input  logic        mem_rd_en,
    output logic [31:0] mem_rd_data,
    output logic        spi_start,
    output logic [7:0]  spi_tx_data,
    output logic        spi_soft_rst,
    input  logic        spi_busy,
    input  logic        spi_ready,
    input  logic [7:0]  spi_rx_data,
`ifdef SPI_BURST_CS_EN
    output logic        spi_cs_n,
`endif
    output logic        irq
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int TW    = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, CAPTURE} state_e;

    state_e          state_q;
    logic [TW-1:0]   to_cnt_q;
    logic            spi_start_q, spi_soft_rst_q, timeout_err_q, tx_ovf_q, irq_en_q;
    logic [7:0]      spi_tx_data_q;
    logic [7:0]      tx_mem_q [DEPTH];
    logic [7:0]      rx_mem_q [DEPTH];
    logic [PW-1:0]   tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [PW-1:0]   tx_wp_d, tx_rp_d, rx_wp_d, rx_rp_d;
    logic [PW-1:0]   tx_cnt, rx_cnt;
    logic            tx_empty, tx_full, rx_empty, rx_full;
    logic            tx_push, tx_pop, rx_push, rx_pop;
    logic [7:0]      tx_head, rx_head;
    logic            unused_bits;

    // MMIO decode
    logic ctrl_wr, push_wr, pop_rd, flush_tx, flush_rx, clr_err, soft_rst;
    assign ctrl_wr  = (mem_addr == 8'h00) && mem_wr_en[0];
    assign push_wr  = (mem_addr == 8'h01) && mem_wr_en[0];
    assign pop_rd   = (mem_addr == 8'h02) && mem_rd_en;
    assign flush_tx = ctrl_wr && mem_wr_data[0];
    assign flush_rx = ctrl_wr && mem_wr_data[1];
    assign clr_err  = ctrl_wr && mem_wr_data[2];
    assign soft_rst = ctrl_wr && mem_wr_data[3];
    assign unused_bits = ^{mem_wr_data, mem_wr_en[3:1]};

    assign tx_cnt   = tx_wp_q - tx_rp_q;
    assign rx_cnt   = rx_wp_q - rx_rp_q;
    assign tx_empty = (tx_cnt == '0);
    assign rx_empty = (rx_cnt == '0);
    assign tx_full  = (tx_cnt == PW'(DEPTH));
    assign rx_full  = (rx_cnt == PW'(DEPTH));
    assign tx_head  = tx_mem_q[tx_rp_q[DEPTH_LOG2-1:0]];
    assign rx_head  = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q[DEPTH_LOG2-1:0]];

    // Flush and soft reset both suppress a same-cycle FSM pop/push.
    assign tx_push = push_wr && !tx_full && !flush_tx;
    assign tx_pop  = (state_q == IDLE) && !tx_empty && !rx_full && !soft_rst && !flush_tx;
    assign rx_push = (state_q == CAPTURE) && !rx_full && !soft_rst && !flush_rx;
    assign rx_pop  = pop_rd && !rx_empty && !flush_rx;

    always_comb begin
        tx_wp_d = tx_wp_q + PW'(tx_push);
        tx_rp_d = tx_rp_q + PW'(tx_pop);
        rx_wp_d = rx_wp_q + PW'(rx_push);
        rx_rp_d = rx_rp_q + PW'(rx_pop);
        if (flush_tx) begin
            tx_wp_d = '0;
            tx_rp_d = '0;
        end
        if (flush_rx) begin
            rx_wp_d = '0;
            rx_rp_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wp_q <= '0;
            tx_rp_q <= '0;
            rx_wp_q <= '0;
            rx_rp_q <= '0;
        end else begin
            tx_wp_q <= tx_wp_d;
            tx_rp_q <= tx_rp_d;
            rx_wp_q <= rx_wp_d;
            rx_rp_q <= rx_rp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wp_q[DEPTH_LOG2-1:0]] <= mem_wr_data[7:0];
        if (rx_push) rx_mem_q[rx_wp_q[DEPTH_LOG2-1:0]] <= spi_rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_ovf_q <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en_q <= mem_wr_data[4];
            if (clr_err) tx_ovf_q <= 1'b0;
            if (push_wr && tx_full) tx_ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            to_cnt_q       <= '0;
            spi_start_q    <= 1'b0;
            spi_soft_rst_q <= 1'b0;
            spi_tx_data_q  <= 8'h00;
            timeout_err_q  <= 1'b0;
        end else begin
            spi_start_q    <= 1'b0;
            spi_soft_rst_q <= soft_rst;
            if (clr_err) timeout_err_q <= 1'b0;
            if (soft_rst) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (tx_pop) begin
                        spi_tx_data_q <= tx_head;
                        spi_start_q   <= 1'b1;
                        state_q       <= ISSUE;
                    end
                    ISSUE: begin
                        to_cnt_q <= '0;
                        state_q  <= WAIT_BUSY;
                    end
                    WAIT_BUSY: begin
                        if (spi_busy) begin
                            state_q <= WAIT_DONE;
                        end else if (to_cnt_q == TW'(BUSY_TIMEOUT - 1)) begin
                            timeout_err_q <= 1'b1;
                            state_q       <= IDLE;
                        end else begin
                            to_cnt_q <= to_cnt_q + 1'b1;
                        end
                    end
                    WAIT_DONE: if (!spi_busy && spi_ready) state_q <= CAPTURE;
                    CAPTURE:   state_q <= IDLE;
                    default:   state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef SPI_BURST_CS_EN
    logic spi_cs_n_q, hold_cs_q;
    // Release one clk after the last capture, or as soon as an idle, empty queue is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_cs_n_q <= 1'b1;
            hold_cs_q  <= 1'b0;
        end else begin
            if (ctrl_wr) hold_cs_q <= mem_wr_data[5];
            if (soft_rst)
                spi_cs_n_q <= 1'b1;
            else if (state_q == WAIT_BUSY && !spi_busy && to_cnt_q == TW'(BUSY_TIMEOUT - 1))
                spi_cs_n_q <= 1'b1;
            else if (tx_pop)
                spi_cs_n_q <= 1'b0;
            else if ((state_q == CAPTURE || state_q == IDLE) && tx_empty && !hold_cs_q)
                spi_cs_n_q <= 1'b1;
        end
    end
    assign spi_cs_n = spi_cs_n_q;
`endif

    always_comb begin
        mem_rd_data = 32'h0;
        case (mem_addr)
            8'h02: mem_rd_data = {23'b0, !rx_empty, rx_head};
            8'h03: mem_rd_data = {12'b0, irq_en_q, timeout_err_q, tx_ovf_q, (state_q == IDLE),
                                  {(8-PW){1'b0}}, rx_cnt, {(8-PW){1'b0}}, tx_cnt};
            default: mem_rd_data = 32'h0;
        endcase
    end

    assign spi_start    = spi_start_q;
    assign spi_tx_data  = spi_tx_data_q;
    assign spi_soft_rst = spi_soft_rst_q;
    assign irq          = (tx_empty && (state_q == IDLE) && irq_en_q) || timeout_err_q || tx_ovf_q;
endmodule

// File: tb/tb_spi_burst_fifo.sv
// Directed bench for spi_burst_fifo with a behavioural SPI driver stub.
module tb_spi_burst_fifo;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  mem_addr;
    logic [3:0]  mem_wr_en;
    logic [31:0] mem_wr_data;
    logic        mem_rd_en;
    logic [31:0] mem_rd_data;
    logic        spi_start, spi_soft_rst, spi_busy, spi_ready, irq;
    logic [7:0]  spi_tx_data, spi_rx_data;
`ifdef SPI_BURST_CS_EN
    logic        spi_cs_n;
`endif

    int checks = 0;
    int errors = 0;
    int starts = 0;
    int stub_mode = 0;   // 0 normal, 1 never busy, 2 busy forever until mode changes

    always #5 clk = ~clk;

    spi_burst_fifo dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
        .mem_wr_data(mem_wr_data), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .spi_start(spi_start), .spi_tx_data(spi_tx_data), .spi_soft_rst(spi_soft_rst),
        .spi_busy(spi_busy), .spi_ready(spi_ready), .spi_rx_data(spi_rx_data),
`ifdef SPI_BURST_CS_EN
        .spi_cs_n(spi_cs_n),
`endif
        .irq(irq)
    );

    always @(negedge clk) if (spi_start) starts++;

`ifdef SPI_BURST_CS_EN
    int   cs_falls = 0;
    int   cs_bad   = 0;
    logic cs_prev  = 1'b1;
    always @(negedge clk) begin
        if (cs_prev && !spi_cs_n) cs_falls++;
        if (spi_start && spi_cs_n) cs_bad++;
        cs_prev = spi_cs_n;
    end
`endif

    // Downstream stub: busy 2 clk after start, ready 3 clk later with rx = ~tx.
    initial begin
        logic [7:0] rx;
        spi_busy = 1'b0; spi_ready = 1'b0; spi_rx_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (spi_start && stub_mode != 1) begin
                rx = ~spi_tx_data;
                repeat (2) @(posedge clk);
                #1 spi_busy = 1'b1;
                if (stub_mode == 2) wait (stub_mode != 2);
                repeat (3) @(posedge clk);
                #1 spi_busy = 1'b0; spi_ready = 1'b1; spi_rx_data = rx;
                @(posedge clk);
                #1 spi_ready = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_addr = a; mem_wr_en = 4'hF; mem_wr_data = d;
        @(negedge clk);
        mem_wr_en = 4'h0; mem_addr = 8'h00;
    endtask

    task automatic rd(input logic [7:0] a, input logic pop, output logic [31:0] d);
        @(negedge clk);
        mem_addr = a; mem_rd_en = pop;
        #1 d = mem_rd_data;
        @(negedge clk);
        mem_rd_en = 1'b0; mem_addr = 8'h00;
    endtask

    initial begin
        logic [31:0] st;
        int s0;
        rst = 1'b1; mem_addr = 8'h00; mem_wr_en = 4'h0; mem_wr_data = 32'h0; mem_rd_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_start", {31'b0, spi_start}, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_softrst", {31'b0, spi_soft_rst}, 32'h0);
`ifdef SPI_BURST_CS_EN
        chk("rst_cs_n", {31'b0, spi_cs_n}, 32'h1);
`endif
        rst = 1'b0;
        rd(8'h03, 1'b0, st);
        chk("rst_status", st, 32'h0001_0000);

        // Two-byte burst
        s0 = starts;
        wr(8'h01, 32'hA5); wr(8'h01, 32'h3C);
        repeat (40) @(negedge clk);
        chk("t1_starts", starts - s0, 2);
        rd(8'h03, 1'b0, st);
        chk("t1_rxcnt", {24'b0, st[15:8]}, 32'd2);
        rd(8'h02, 1'b1, st); chk("t1_pop0", st, 32'h15A);
        rd(8'h02, 1'b1, st); chk("t1_pop1", st, 32'h1C3);
        rd(8'h02, 1'b1, st); chk("t1_empty_pop", st, 32'h0);
        chk("t1_irq_off", {31'b0, irq}, 32'h0);
        wr(8'h00, 32'h10);
        chk("t1_irq_on", {31'b0, irq}, 32'h1);

        // RX full stalls the FSM until a pop
        s0 = starts;
        for (int i = 0; i < 10; i++) wr(8'h01, 32'h10 + i);
        repeat (120) @(negedge clk);
        chk("t4_starts8", starts - s0, 8);
        rd(8'h03, 1'b0, st);
        chk("t4_rxcnt", {24'b0, st[15:8]}, 32'd8);
        chk("t4_txcnt", {24'b0, st[7:0]}, 32'd2);
        repeat (50) @(negedge clk);
        chk("t4_stalled", starts - s0, 8);
        rd(8'h02, 1'b1, st); chk("t4_pop", st, 32'h1EF);
        repeat (30) @(negedge clk);
        chk("t4_resume", starts - s0, 9);
        rd(8'h03, 1'b0, st);
        chk("t4_txcnt1", {24'b0, st[7:0]}, 32'd1);
        wr(8'h00, 32'h03);
        rd(8'h03, 1'b0, st);
        chk("t4_flushed", {16'b0, st[15:0]}, 32'h0);

        // Soft reset while waiting for done
        stub_mode = 2;
        wr(8'h01, 32'h77);
        repeat (10) @(negedge clk);
        rd(8'h03, 1'b0, st);
        chk("t5_busy", {31'b0, st[16]}, 32'h0);
        wr(8'h00, 32'h08);
        chk("t5_pulse", {31'b0, spi_soft_rst}, 32'h1);
        @(negedge clk);
        chk("t5_pulse_end", {31'b0, spi_soft_rst}, 32'h0);
        rd(8'h03, 1'b0, st);
        chk("t5_idle", {31'b0, st[16]}, 32'h1);
        chk("t5_rxcnt", {24'b0, st[15:8]}, 32'h0);
        stub_mode = 0;
        repeat (15) @(negedge clk);
        rd(8'h03, 1'b0, st);
        chk("t5_no_push", {24'b0, st[15:8]}, 32'h0);

        // Busy timeout
        stub_mode = 1;
        wr(8'h01, 32'h55);
        repeat (200) @(negedge clk);
        rd(8'h03, 1'b0, st);
        chk("t3_no_err_yet", {31'b0, st[18]}, 32'h0);
        repeat (100) @(negedge clk);
        rd(8'h03, 1'b0, st);
        chk("t3_err", {31'b0, st[18]}, 32'h1);
        chk("t3_idle", {31'b0, st[16]}, 32'h1);
        chk("t3_rxcnt", {24'b0, st[15:8]}, 32'h0);
        chk("t3_irq", {31'b0, irq}, 32'h1);

        // TX overflow with the FSM stuck on a primed byte
        wr(8'h00, 32'h04);
        rd(8'h03, 1'b0, st);
        chk("t2_err_clr", {31'b0, st[18]}, 32'h0);
        wr(8'h01, 32'h01);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 9; i++) wr(8'h01, 32'h20 + i);
        rd(8'h03, 1'b0, st);
        chk("t2_txcnt", {24'b0, st[7:0]}, 32'd8);
        chk("t2_ovf", {31'b0, st[17]}, 32'h1);
        chk("t2_irq", {31'b0, irq}, 32'h1);
        wr(8'h00, 32'h04);
        rd(8'h03, 1'b0, st);
        chk("t2_ovf_clr", {31'b0, st[17]}, 32'h0);
        chk("t2_txcnt_kept", {24'b0, st[7:0]}, 32'd8);
        wr(8'h00, 32'h09);
        chk("t2_softrst", {31'b0, spi_soft_rst}, 32'h1);
        rd(8'h03, 1'b0, st);
        chk("t2_idle", {31'b0, st[16]}, 32'h1);
        chk("t2_txflush", {24'b0, st[7:0]}, 32'h0);
        stub_mode = 0;

`ifdef SPI_BURST_CS_EN
        begin
            int f0;
            repeat (10) @(negedge clk);
            f0 = cs_falls; s0 = starts;
            chk("t6_cs_idle", {31'b0, spi_cs_n}, 32'h1);
            for (int i = 0; i < 3; i++) wr(8'h01, 32'h40 + i);
            repeat (40) @(negedge clk);
            chk("t6_starts", starts - s0, 3);
            chk("t6_windows", cs_falls - f0, 1);
            chk("t6_cs_at_start", cs_bad, 0);
            chk("t6_cs_release", {31'b0, spi_cs_n}, 32'h1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
